// File: rtl/exec_ready_seq_if.sv
// Handshake bundle between decode/control, the multi-cycle ALU unit and data memory.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface exec_ready_seq_if #(
    parameter int OPSEL_W = 5
);
    logic               instr_valid;
    logic               is_multi;
    logic               is_mem;
    logic [OPSEL_W-1:0] opsel;
    logic               mu_start;
    logic [OPSEL_W-1:0] mu_opsel;
    logic               mu_done;
    logic               mem_req;
    logic               mem_ack;
    logic               ready;
    logic               busy;
    logic               timeout;

    modport master (
        output instr_valid, is_multi, is_mem, opsel, mu_done, mem_ack,
        input  mu_start, mu_opsel, mem_req, ready, busy, timeout
    );

    modport slave (
        input  instr_valid, is_multi, is_mem, opsel, mu_done, mem_ack,
        output mu_start, mu_opsel, mem_req, ready, busy, timeout
    );
endinterface

// File: rtl/exec_ready_seq.sv
// Instruction-complete sequencer: issues one ready per instruction, starting the
// multi-cycle unit or waiting on data memory as needed, with a bounded wait.
module exec_ready_seq #(
    parameter int OPSEL_W     = 5,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input logic             clk,
    input logic             rst_n,
    exec_ready_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MU_START = 3'd1,
        MU_WAIT  = 3'd2,
        MEM_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [OPSEL_W-1:0] opsel_q, opsel_nxt;
    logic               timeout_q, timeout_nxt;
    logic               ready_c, mu_start_c, mem_req_c;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opsel_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            opsel_q   <= opsel_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        opsel_nxt   = opsel_q;
        timeout_nxt = timeout_q;
        ready_c     = 1'b0;
        mu_start_c  = 1'b0;
        mem_req_c   = 1'b0;
        case (state)
            IDLE: begin
                // is_multi wins over is_mem; single-cycle ops complete without leaving IDLE
                if (bus.instr_valid) begin
                    if (bus.is_multi) begin
                        opsel_nxt = bus.opsel;
                        state_nxt = MU_START;
                    end else if (bus.is_mem) begin
                        cnt_nxt   = '0;
                        state_nxt = MEM_WAIT;
                    end else begin
                        ready_c = 1'b1;
                    end
                end
            end
            MU_START: begin
                mu_start_c = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = bus.mu_done ? DONE : MU_WAIT;
            end
            MU_WAIT: begin
                if (bus.mu_done) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt_sat_inc(cnt);
                end
            end
            MEM_WAIT: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt_sat_inc(cnt);
                end
            end
            DONE: begin
                ready_c   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A completion in flight when reset arrives is dropped rather than reported.
    assign bus.ready    = ready_c & rst_n;
    assign bus.mu_start = mu_start_c;
    assign bus.mem_req  = mem_req_c;
    assign bus.mu_opsel = opsel_q;
    assign bus.busy     = (state != IDLE);
    assign bus.timeout  = timeout_q;

endmodule
